scr1_pipe_mprf_wbarb: RTL

SCR1_PIPE_MPRF_WBARB -- requirements
Module: scr1_pipe_mprf_wbarb

---
 rtl/scr1_arch_description.sv | 7 +
 rtl/scr1_arch_types.sv | 10 +
 rtl/scr1_pipe_mprf_wb_fifo.sv | 58 +++++
 rtl/scr1_pipe_mprf_wbarb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/scr1_arch_description.sv
// SCR1 architecture configuration constants.
// No ports: shared defaults for pipeline blocks.
package scr1_arch_description;

  localparam int unsigned SCR1_WB_FIFO_DEPTH = 2;

endpackage

// File: rtl/scr1_arch_types.sv
// SCR1 shared architectural types.
// No ports: writeback entry carried from LSU to MPRF.
package scr1_arch_types;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } type_scr1_mprf_wb_s;

endpackage

// File: rtl/scr1_pipe_mprf_wb_fifo.sv
// In-order FIFO for the MPRF writeback arbiter.
// Ports: clk/rst_n, push/data in, pop, head/full/empty out.
module scr1_pipe_mprf_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a full FIFO takes a push only when a slot frees this cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scr1_pipe_mprf_wbarb.sv
// MPRF writeback arbiter: EXU vs buffered load results.
// Ports: EXU wb req/rdy, LSU issue/rsp, hazards, MPRF write.
module scr1_pipe_mprf_wbarb
  import scr1_arch_types::*;
  import scr1_arch_description::*;
#(
  parameter int unsigned WB_FIFO_DEPTH = SCR1_WB_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu_wb_req_i,
  input  logic [4:0]  exu_wb_addr_i,
  input  logic [31:0] exu_wb_data_i,
  output logic        exu_wb_rdy_o,
  input  logic        lsu_issue_i,
  input  logic [4:0]  lsu_issue_rd_i,
  input  logic        lsu_rsp_vd_i,
  input  logic [31:0] lsu_rsp_data_i,
  output logic        lsu_rsp_rdy_o,
  input  logic [4:0]  exu_rs1_addr_i,
  input  logic [4:0]  exu_rs2_addr_i,
  input  logic [4:0]  exu_rd_addr_i,
  output logic        exu_rs1_hzd_o,
  output logic        exu_rs2_hzd_o,
  output logic        exu_rd_hzd_o,
  output logic        mprf_w_req_o,
  output logic [4:0]  mprf_rd_addr_o,
  output logic [31:0] mprf_rd_data_o
);

  localparam int unsigned EW = $bits(type_scr1_mprf_wb_s);

  logic               rdq_full;
  logic               rdq_empty;
  logic [4:0]         rdq_head;
  logic               wb_full;
  logic               wb_empty;
  type_scr1_mprf_wb_s wb_in;
  type_scr1_mprf_wb_s wb_head;
  logic               rsp_acc;
  logic               issue_acc;
  logic               exu_gnt;
  logic               fifo_gnt;
  logic [31:0]        pending;
  logic [31:0]        set_mask;
  logic [31:0]        clr_mask;

  assign rsp_acc   = lsu_rsp_vd_i & ~wb_full;
  assign issue_acc = lsu_issue_i & (~rdq_full | rsp_acc);
  assign exu_gnt   = exu_wb_req_i & ~wb_full;
  // head drains when idle, or forcibly once the FIFO is full
  assign fifo_gnt  = ~wb_empty & (~exu_wb_req_i | wb_full);

  assign lsu_rsp_rdy_o = ~wb_full;
  assign exu_wb_rdy_o  = ~wb_full;

  assign wb_in.rd   = rdq_head;
  assign wb_in.data = lsu_rsp_data_i;

  scr1_pipe_mprf_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH),
    .WIDTH (5)
  ) i_rd_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lsu_issue_i),
    .pop   (rsp_acc),
    .data  (lsu_issue_rd_i),
    .head  (rdq_head),
    .full  (rdq_full),
    .empty (rdq_empty)
  );

  scr1_pipe_mprf_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH),
    .WIDTH (EW)
  ) i_data_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_acc),
    .pop   (fifo_gnt),
    .data  (wb_in),
    .head  (wb_head),
    .full  (wb_full),
    .empty (wb_empty)
  );

  always_comb begin
    mprf_w_req_o   = 1'b0;
    mprf_rd_addr_o = '0;
    mprf_rd_data_o = '0;
    unique case (1'b1)
      exu_gnt: begin
        mprf_w_req_o   = 1'b1;
        mprf_rd_addr_o = exu_wb_addr_i;
        mprf_rd_data_o = exu_wb_data_i;
      end
      fifo_gnt: begin
        // rd 0 loads pop silently
        if (|wb_head.rd) begin
          mprf_w_req_o   = 1'b1;
          mprf_rd_addr_o = wb_head.rd;
          mprf_rd_data_o = wb_head.data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_acc & (|lsu_issue_rd_i)) begin
      set_mask[lsu_issue_rd_i] = 1'b1;
    end
    if (fifo_gnt & (|wb_head.rd)) begin
      clr_mask[wb_head.rd] = 1'b1;
    end
  end

  // set after clear: a re-issued rd stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign exu_rs1_hzd_o = pending[exu_rs1_addr_i] & (|exu_rs1_addr_i);
  assign exu_rs2_hzd_o = pending[exu_rs2_addr_i] & (|exu_rs2_addr_i);
  assign exu_rd_hzd_o  = pending[exu_rd_addr_i] & (|exu_rd_addr_i);

  a_issue_full: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(lsu_issue_i & rdq_full & ~rsp_acc));

  a_exu_pending: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(exu_gnt & pending[exu_wb_addr_i] & (|exu_wb_addr_i)));

  a_rsp_orphan: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(rsp_acc & rdq_empty));

endmodule
